poly_voice_engine: RTL and testbench

//  Parametrised polyphonic voice engine; successor to the per-key data path. Holds NUM_VOICES

---
 rtl/poly_voice_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_poly_voice_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_engine.sv
// Polyphonic voice engine: dynamically allocated voices (phase accumulator + ADSR + velocity),
// swept through an external wavetable on each sample request and mixed into one saturated sample.
module poly_voice_engine #(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 24,
    parameter int TBL_AW     = 12,
    parameter int WSEL_W     = 1,
    parameter int SAMPLE_W   = 16,
    parameter int ENV_W      = 16,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 24
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_on,
    input  logic [6:0]                 i_cmd_key,
    input  logic [6:0]                 i_cmd_vel,
    input  logic [PHASE_W-1:0]         i_cmd_step,
    input  logic [ENV_W-1:0]           i_att_step,
    input  logic [ENV_W-1:0]           i_dec_step,
    input  logic [ENV_W-1:0]           i_rel_step,
    input  logic [ENV_W-1:0]           i_sus_lvl,
    input  logic [WSEL_W-1:0]          i_wave_sel,
    input  logic                       i_sample_req,
    output logic [WSEL_W+TBL_AW-1:0]   o_tbl_addr,
    input  logic signed [SAMPLE_W-1:0] i_tbl_data,
    output logic signed [OUT_W-1:0]    o_out_sample,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [6:0]                 o_active_cnt,
    output logic                       o_overrun
);
    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int AMP_W  = 12;
    localparam int EV_W   = ENV_W + 7;
    localparam int PROD_W = SAMPLE_W + AMP_W;
    localparam int DIF_W  = ENV_W + 2;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [ENV_W-1:0]        ENV_FULL = '1;
    localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] OUT_MIN  = ~OUT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;
    typedef enum logic [2:0] {V_OFF, V_ATT, V_DEC, V_SUS, V_REL} vstage_t;

    vstage_t              r_stage [NUM_VOICES];
    logic [ENV_W-1:0]     r_env   [NUM_VOICES];
    logic [PHASE_W-1:0]   r_phase [NUM_VOICES];
    logic [PHASE_W-1:0]   r_step  [NUM_VOICES];
    logic [6:0]           r_vel   [NUM_VOICES];
    logic [6:0]           r_key   [NUM_VOICES];
    logic [IDX_W-1:0]     r_steal;

    state_t                     r_state, w_next_state;
    logic [IDX_W-1:0]           r_idx, r_idx_p1;
    logic [1:0]                 r_drain;
    logic                       r_ready;
    logic                       r_vld_p1, r_vld_p2;
    logic signed [PROD_W-1:0]   r_prod_p2;
    logic signed [ACC_W-1:0]    r_acc;

    logic                       w_cmd_acc, w_hit, w_free;
    logic [IDX_W-1:0]           w_hit_idx, w_free_idx, w_alloc_idx;
    logic [6:0]                 w_cnt;
    logic [EV_W-1:0]            w_ev;
    logic [AMP_W-1:0]           w_amp;
    logic signed [PROD_W-1:0]   w_data_x, w_amp_x, w_prod;
    logic [ENV_W-1:0]           w_env_cur, w_env_nxt;
    vstage_t                    w_stage_nxt;
    logic signed [DIF_W-1:0]    w_att_sum, w_dec_dif, w_rel_dif;

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        if (a > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
        else if (a < OUT_MIN) return OUT_MIN[OUT_W-1:0];
        else                  return a[OUT_W-1:0];
    endfunction

    assign w_cmd_acc    = i_cmd_valid & r_ready;
    assign o_cmd_ready  = r_ready;
    assign o_active_cnt = w_cnt;
    assign o_tbl_addr   = (r_state == S_SWEEP) ?
                          {i_wave_sel, r_phase[r_idx][PHASE_W-1 -: TBL_AW]} : '0;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_sample_req) w_next_state = S_SWEEP;
            S_SWEEP: if (r_idx == LAST_IDX) w_next_state = S_DRAIN;
            S_DRAIN: if (r_drain == 2'd2) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_cnt      = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_stage[i] != V_OFF && r_key[i] == i_cmd_key) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (r_stage[i] == V_OFF) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            w_cnt = w_cnt + 7'(r_stage[i] != V_OFF);
        end
        w_alloc_idx = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_steal);
    end

    always_comb begin
        w_ev      = EV_W'(r_env[r_idx_p1]) * EV_W'(r_vel[r_idx_p1]);
        w_amp     = AMP_W'(w_ev >> (ENV_W - 5));
        w_data_x  = PROD_W'(i_tbl_data);
        w_amp_x   = $signed(PROD_W'(w_amp));
        w_prod    = w_data_x * w_amp_x;
        w_env_cur = r_env[r_idx_p1];
        w_att_sum = $signed({2'b00, w_env_cur}) + $signed({2'b00, i_att_step});
        w_dec_dif = $signed({2'b00, w_env_cur}) - $signed({2'b00, i_dec_step});
        w_rel_dif = $signed({2'b00, w_env_cur}) - $signed({2'b00, i_rel_step});
        w_env_nxt   = w_env_cur;
        w_stage_nxt = r_stage[r_idx_p1];
        case (r_stage[r_idx_p1])
            V_ATT: begin
                if (w_att_sum >= $signed({2'b00, ENV_FULL})) begin
                    w_env_nxt   = ENV_FULL;
                    w_stage_nxt = V_DEC;
                end else begin
                    w_env_nxt = w_att_sum[ENV_W-1:0];
                end
            end
            V_DEC: begin
                if (w_dec_dif <= $signed({2'b00, i_sus_lvl})) begin
                    w_env_nxt   = i_sus_lvl;
                    w_stage_nxt = V_SUS;
                end else begin
                    w_env_nxt = w_dec_dif[ENV_W-1:0];
                end
            end
            V_REL: begin
                if (w_rel_dif <= 0) begin
                    w_env_nxt   = '0;
                    w_stage_nxt = V_OFF;
                end else begin
                    w_env_nxt = w_rel_dif[ENV_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Commands only land in IDLE and voice updates only in SWEEP/DRAIN, so they never collide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_stage[i] <= V_OFF;
                r_env[i]   <= '0;
                r_phase[i] <= '0;
                r_step[i]  <= '0;
                r_vel[i]   <= '0;
                r_key[i]   <= '0;
            end
            r_steal <= '0;
        end else begin
            if (w_cmd_acc && i_cmd_on) begin
                r_stage[w_alloc_idx] <= V_ATT;
                r_vel[w_alloc_idx]   <= i_cmd_vel;
                r_step[w_alloc_idx]  <= i_cmd_step;
                r_key[w_alloc_idx]   <= i_cmd_key;
                if (!w_hit) begin
                    r_env[w_alloc_idx]   <= '0;
                    r_phase[w_alloc_idx] <= '0;
                end
                if (!w_hit && !w_free) r_steal <= r_steal + IDX_W'(1);
            end else if (w_cmd_acc) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (r_key[i] == i_cmd_key &&
                        (r_stage[i] == V_ATT || r_stage[i] == V_DEC || r_stage[i] == V_SUS))
                        r_stage[i] <= V_REL;
                end
            end
            if (r_vld_p1 && r_stage[r_idx_p1] != V_OFF) begin
                r_phase[r_idx_p1] <= r_phase[r_idx_p1] + r_step[r_idx_p1];
                r_env[r_idx_p1]   <= w_env_nxt;
                r_stage[r_idx_p1] <= w_stage_nxt;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_drain      <= '0;
            r_ready      <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_vld_p2     <= 1'b0;
            r_acc        <= '0;
            o_out_sample <= '0;
            o_out_valid  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_ready  <= (w_next_state == S_IDLE);
            r_idx    <= (r_state == S_SWEEP) ? r_idx + IDX_W'(1) : '0;
            r_drain  <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
            // stage p0 -> p1: address issued, table word arrives next cycle
            r_vld_p1 <= (r_state == S_SWEEP);
            // stage p1 -> p2: product registered
            r_vld_p2 <= r_vld_p1;
            // stage p2: accumulate
            if (r_state == S_IDLE && i_sample_req) r_acc <= '0;
            else if (r_vld_p2)                     r_acc <= r_acc + ACC_W'(r_prod_p2);
            if (r_state == S_DRAIN && r_drain == 2'd2) begin
                o_out_sample <= sat_out(r_acc);
                o_out_valid  <= 1'b1;
                if (o_out_valid && !i_out_ready) o_overrun <= 1'b1;
            end else if (o_out_valid && i_out_ready) begin
                o_out_valid <= 1'b0;
            end
            if (r_state != S_IDLE && i_sample_req) o_overrun <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        r_idx_p1  <= r_idx;
        r_prod_p2 <= (r_vld_p1 && r_stage[r_idx_p1] != V_OFF) ? w_prod : '0;
    end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Randomised bench for poly_voice_engine against a voice-level behavioural model,
// plus hand-computed expectations for the key scenarios.
module tb_poly_voice_engine;
    localparam int N = 16;
    localparam int OFF = 0, ATT = 1, DEC = 2, SUS = 3, REL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               cmd_valid, cmd_ready, cmd_on;
    logic [6:0]         cmd_key, cmd_vel;
    logic [23:0]        cmd_step;
    logic [15:0]        att, dec, rel, sus;
    logic [0:0]         wsel;
    logic               sample_req;
    logic [12:0]        tbl_addr;
    logic signed [15:0] tbl_data;
    logic signed [23:0] out_sample;
    logic               out_valid, out_ready;
    logic [6:0]         active_cnt;
    logic               overrun;

    poly_voice_engine dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_on(cmd_on),
        .i_cmd_key(cmd_key), .i_cmd_vel(cmd_vel), .i_cmd_step(cmd_step),
        .i_att_step(att), .i_dec_step(dec), .i_rel_step(rel), .i_sus_lvl(sus),
        .i_wave_sel(wsel), .i_sample_req(sample_req),
        .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
        .o_out_sample(out_sample), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_active_cnt(active_cnt), .o_overrun(overrun)
    );

    int rom_mode;
    int checks = 0;
    int errors = 0;

    function automatic logic signed [15:0] rom_f(input int unsigned addr);
        int unsigned h;
        h = addr * 32'h9E3779B1;
        h = h ^ (h >> 15);
        if (rom_mode == 0)      return 16'sh7FFF;
        else if (rom_mode == 1) return 16'sh8000;
        else                    return h[31:16];
    endfunction

    always @(posedge clk) tbl_data <= rom_f(32'(tbl_addr));

    // Voice-level reference model
    int          m_stage [N];
    int          m_env   [N];
    int          m_key   [N];
    int          m_vel   [N];
    int unsigned m_phase [N];
    int unsigned m_step  [N];
    int          m_ptr;
    bit          m_overrun, m_pending;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_active();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_stage[i] != OFF) c++;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_stage[i] = OFF; m_env[i] = 0; m_key[i] = 0;
            m_vel[i] = 0; m_phase[i] = 0; m_step[i] = 0;
        end
        m_ptr = 0; m_overrun = 0; m_pending = 0;
    endtask

    task automatic m_note_on(input int key, input int vel, input int unsigned step);
        int idx = -1;
        for (int i = 0; i < N; i++) if (idx < 0 && m_stage[i] != OFF && m_key[i] == key) idx = i;
        if (idx >= 0) begin
            m_stage[idx] = ATT; m_vel[idx] = vel; m_step[idx] = step;
        end else begin
            for (int i = 0; i < N; i++) if (idx < 0 && m_stage[i] == OFF) idx = i;
            if (idx < 0) begin
                idx = m_ptr;
                m_ptr = (m_ptr + 1) % N;
            end
            m_stage[idx] = ATT; m_vel[idx] = vel; m_step[idx] = step;
            m_key[idx] = key; m_env[idx] = 0; m_phase[idx] = 0;
        end
    endtask

    task automatic m_note_off(input int key);
        for (int i = 0; i < N; i++)
            if (m_key[i] == key && (m_stage[i] == ATT || m_stage[i] == DEC || m_stage[i] == SUS))
                m_stage[i] = REL;
    endtask

    task automatic m_sweep(output int res);
        int acc = 0;
        int d, amp, e;
        int unsigned addr;
        for (int i = 0; i < N; i++) begin
            if (m_stage[i] != OFF) begin
                addr = (int'(wsel) << 12) | (m_phase[i] >> 12);
                d    = int'(rom_f(addr));
                amp  = ((m_env[i] * m_vel[i]) >> 11) & 'hFFF;
                acc  = acc + d * amp;
                m_phase[i] = (m_phase[i] + m_step[i]) & 32'hFFFFFF;
                case (m_stage[i])
                    ATT: begin
                        e = m_env[i] + int'(att);
                        if (e >= 65535) begin m_env[i] = 65535; m_stage[i] = DEC; end
                        else m_env[i] = e;
                    end
                    DEC: begin
                        e = m_env[i] - int'(dec);
                        if (e <= int'(sus)) begin m_env[i] = int'(sus); m_stage[i] = SUS; end
                        else m_env[i] = e;
                    end
                    REL: begin
                        e = m_env[i] - int'(rel);
                        if (e <= 0) begin m_env[i] = 0; m_stage[i] = OFF; end
                        else m_env[i] = e;
                    end
                    default: ;
                endcase
            end
        end
        if (acc > 8388607)       res = 8388607;
        else if (acc < -8388608) res = -8388608;
        else                     res = acc;
    endtask

    // Idle-time monitor: voice count, sticky flag and quiet table bus
    always @(negedge clk) begin
        if (rst_n && cmd_ready) begin
            chk("active_cnt", active_cnt, m_active());
            chk("overrun", overrun, m_overrun);
            chk("tbl_addr_idle", tbl_addr, 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        cmd_valid = 0; sample_req = 0; out_ready = 0;
        m_reset();
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_active_cnt", active_cnt, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("ready_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", cmd_ready, 1);
    endtask

    task automatic issue(input bit has_cmd, input bit on, input int key, input int vel,
                         input int unsigned step, input bit has_req, input bit drop,
                         input bit consume, output int got);
        int exp, seen, drop_k;
        bit pend;
        got = 0;
        @(negedge clk);
        cmd_valid = has_cmd; cmd_on = on; cmd_key = 7'(key); cmd_vel = 7'(vel);
        cmd_step = 24'(step); sample_req = has_req;
        @(posedge clk);
        #1;
        cmd_valid = 0; sample_req = 0;
        if (has_cmd) begin
            if (on) m_note_on(key, vel, step);
            else    m_note_off(key);
        end
        if (has_req) begin
            m_sweep(exp);
            pend = m_pending;
            if (pend) m_overrun = 1;
            seen = -1;
            drop_k = $urandom_range(2, N);
            for (int k = 2; k <= N + 10; k++) begin
                @(negedge clk);
                sample_req = drop && (k == drop_k);
                @(posedge clk);
                #1;
                sample_req = 0;
                if (drop && k == drop_k) m_overrun = 1;
                if (pend) begin
                    if (k == N + 4) begin seen = k; break; end
                end else if (out_valid) begin
                    seen = k; break;
                end
            end
            chk("latency", seen, N + 4);
            chk("out_valid", out_valid, 1);
            chk("out_sample", out_sample, exp);
            got = int'(out_sample);
            if (consume) begin
                @(negedge clk);
                out_ready = 1;
                @(posedge clk);
                #1;
                out_ready = 0;
                m_pending = 0;
                chk("valid_cleared", out_valid, 0);
            end else begin
                m_pending = 1;
            end
        end
    endtask

    task automatic note(input bit on, input int key, input int vel, input int unsigned step);
        int g;
        issue(1, on, key, vel, step, 0, 0, 0, g);
    endtask

    task automatic samp(input bit drop, input bit consume, output int got);
        issue(0, 0, 0, 0, 0, 1, drop, consume, got);
    endtask

    initial begin
        int g;
        rst_n = 1; cmd_valid = 0; cmd_on = 0; cmd_key = 0; cmd_vel = 0; cmd_step = 0;
        att = 16'hFFFF; dec = 16'h0000; rel = 16'h4000; sus = 16'hFFFF;
        wsel = 0; sample_req = 0; out_ready = 0; rom_mode = 0;

        // Empty engine produces silence after N+4 cycles
        do_reset();
        samp(0, 1, g);
        chk("t1_silence", g, 0);

        // Full-velocity note: first sweep silent, second saturates
        note(1, 60, 127, 24'h001000);
        samp(0, 1, g);
        chk("t2_sweep1", g, 0);
        samp(0, 1, g);
        chk("t2_sweep2_sat", g, 8388607);

        // Velocity 1 gives unsaturated amplitudes; release from full scale takes 4 sweeps
        do_reset();
        note(1, 61, 1, 24'h000800);
        samp(0, 1, g);
        chk("t4_sweep1", g, 0);
        samp(0, 1, g);
        chk("t4_sweep2", g, 32767 * 31);
        note(0, 61, 0, 0);
        samp(0, 1, g);
        chk("t4_rel1", g, 32767 * 31);
        chk("t4_active1", active_cnt, 1);
        samp(0, 1, g);
        chk("t4_rel2", g, 32767 * 23);
        samp(0, 1, g);
        chk("t4_rel3", g, 32767 * 15);
        chk("t4_active3", active_cnt, 1);
        samp(0, 1, g);
        chk("t4_rel4", g, 32767 * 7);
        chk("t4_active4", active_cnt, 0);

        // 17 distinct notes: voice 0 is stolen, then the pointer moves on
        do_reset();
        rom_mode = 2;
        for (int k = 0; k < 17; k++) note(1, 10 + k, 100 - k, 24'($urandom));
        chk("t3_active16", active_cnt, 16);
        note(1, 27, 90, 24'h012345);
        note(0, 11, 0, 0);
        note(0, 12, 0, 0);
        rel = 16'h2000;
        for (int k = 0; k < 6; k++) samp(0, 1, g);

        // Sixteen full-scale voices clamp both ways
        do_reset();
        rom_mode = 0; rel = 16'h4000;
        for (int k = 0; k < 16; k++) note(1, 30 + k, 127, 24'h000100 * k);
        samp(0, 1, g);
        samp(0, 1, g);
        chk("t5_pos_sat", g, 8388607);
        rom_mode = 1;
        samp(0, 1, g);
        chk("t5_neg_sat", g, -8388608);

        // Overrun: unread result overwritten, then a request dropped mid-sweep
        do_reset();
        samp(0, 0, g);
        chk("t6_no_overrun", overrun, 0);
        samp(0, 1, g);
        chk("t6_overwrite", overrun, 1);
        samp(0, 1, g);
        chk("t6_sticky", overrun, 1);
        do_reset();
        samp(1, 1, g);
        chk("t6_dropped", overrun, 1);

        // Randomised traffic
        do_reset();
        for (int it = 0; it < 150; it++) begin
            int ncmd;
            att = 16'($urandom_range(16'h0100, 16'h9000));
            dec = 16'($urandom_range(16'h0040, 16'h3000));
            rel = 16'($urandom_range(16'h0100, 16'h6000));
            sus = 16'($urandom_range(0, 16'hC000));
            wsel = 1'($urandom);
            rom_mode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : 2;
            ncmd = $urandom_range(0, 3);
            for (int c = 0; c < ncmd; c++)
                note($urandom_range(0, 9) < 6, $urandom_range(40, 51),
                     $urandom_range(0, 127), $urandom);
            if ($urandom_range(0, 3) == 0)
                issue(1, $urandom_range(0, 1), $urandom_range(40, 51), $urandom_range(0, 127),
                      $urandom, 1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, g);
            else
                samp($urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, g);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end
endmodule
